// File: rtl/alu_pkg.sv
// alu_pkg: op-code constants, step-sequencer state encoding and the one-hot state display map.
package alu_pkg;
  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;
  localparam logic [5:0] OP_XOR = 6'b100110;
  localparam logic [5:0] OP_NOR = 6'b100111;
  localparam logic [5:0] OP_SRA = 6'b000011;
  localparam logic [5:0] OP_SRL = 6'b000010;
  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_RESULT  = 3'd4
  } state_e;
  function automatic logic [2:0] state_onehot(state_e s);
    return s == ST_LOAD_A ? 3'b001 : s == ST_LOAD_B ? 3'b010 : s == ST_LOAD_OP ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational signed ALU; unknown op codes give result 0 with overflow 0.
module alu
  import alu_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] a_i,
  input  logic [NB_DATA-1:0] b_i,
  input  logic [NB_OP-1:0]   op_i,
  output logic [NB_DATA-1:0] res_o,
  output logic               ovf_o,
  output logic               zero_o
);
  localparam int M = NB_DATA - 1;
  always_comb begin
    res_o = '0;
    ovf_o = 1'b0;
    case (op_i)
      OP_ADD: begin
        res_o = a_i + b_i;
        ovf_o = (a_i[M] == b_i[M]) && (res_o[M] != a_i[M]);
      end
      OP_SUB: begin
        res_o = a_i - b_i;
        ovf_o = (a_i[M] != b_i[M]) && (res_o[M] != a_i[M]);
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_SRA:  res_o = $signed(a_i) >>> b_i;
      OP_SRL:  res_o = a_i >> b_i;
      default: res_o = '0;
    endcase
  end
  assign zero_o = ~|res_o;
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: 2-flop sync, optional debounce (ALU_STEP_DEBOUNCE_EN), rising-edge 1-cycle pulse.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NB_DBC          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic pulse_o
);
  logic [1:0] sync_q;
  logic [1:0] fill_q;
  logic       stable_q;
  logic       armed_q;
  logic       pulse_q;
  logic       accept;
`ifdef ALU_STEP_DEBOUNCE_EN
  logic [NB_DBC-1:0] cnt_q;
  logic              lvl_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= sync_q[1];
      cnt_q <= (sync_q[1] != lvl_q) ? '0 : (cnt_q == NB_DBC'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + NB_DBC'(1);
    end
  end
  assign accept = (sync_q[1] == lvl_q) && (cnt_q == NB_DBC'(DEBOUNCE_CYCLES));
`else
  logic unused_cfg;
  assign unused_cfg = ^{DEBOUNCE_CYCLES, NB_DBC};
  assign accept     = 1'b1;
`endif
  // A button held through reset stays disarmed until a released level is accepted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      fill_q   <= '0;
      stable_q <= 1'b0;
      armed_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      fill_q   <= fill_q[1] ? fill_q : fill_q + 2'd1;
      stable_q <= accept ? sync_q[1] : stable_q;
      armed_q  <= armed_q | (accept && fill_q[1] && !sync_q[1]);
      pulse_q  <= accept && armed_q && sync_q[1] && !stable_q;
    end
  end
  assign pulse_o = pulse_q;
endmodule

// File: rtl/alu_step_loader.sv
// alu_step_loader: one-button step sequencer capturing A, B, op from switches and holding the ALU result.
// Define ALU_STEP_DEBOUNCE_EN for the full button debounce counter.
module alu_step_loader
  import alu_pkg::*;
#(
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NB_DBC          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               I_clk,
  input  logic               reset_button,
  input  logic [NB_DATA-1:0] I_sw,
  input  logic               I_btn_next,
  input  logic               I_btn_back,
  output logic [NB_DATA-1:0] O_led,
  output logic               O_overflow,
  output logic               O_zero,
  output logic [2:0]         O_state,
  output logic               O_valid
);
  state_e             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d, res_q, res_d, led_q, led_d, alu_res;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               ovf_q, ovf_d, zero_q, zero_d, alu_ovf, alu_zero;
  logic               ovf_out_q, zero_out_q, valid_q;
  logic [2:0]         state_out_q;
  logic               next_p, back_p, nx, bk, clr;
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DBC(NB_DBC)) u_btn_next (
    .clk_i(I_clk), .rst_i(reset_button), .btn_i(I_btn_next), .pulse_o(next_p)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .NB_DBC(NB_DBC)) u_btn_back (
    .clk_i(I_clk), .rst_i(reset_button), .btn_i(I_btn_back), .pulse_o(back_p)
  );
  alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .a_i(a_q), .b_i(b_q), .op_i(op_q), .res_o(alu_res), .ovf_o(alu_ovf), .zero_o(alu_zero)
  );
  // Simultaneous next and back cancel each other.
  assign nx = next_p & ~back_p;
  assign bk = back_p & ~next_p;
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD_A:  state_d = nx ? ST_LOAD_B : ST_LOAD_A;
      ST_LOAD_B:  state_d = nx ? ST_LOAD_OP : bk ? ST_LOAD_A : ST_LOAD_B;
      ST_LOAD_OP: state_d = nx ? ST_EXEC : bk ? ST_LOAD_B : ST_LOAD_OP;
      ST_EXEC:    state_d = ST_RESULT;
      ST_RESULT:  state_d = nx ? ST_LOAD_A : bk ? ST_LOAD_OP : ST_RESULT;
      default:    state_d = ST_LOAD_A;
    endcase
  end
  assign clr    = (state_d == ST_LOAD_A) && (state_q != ST_LOAD_A);
  assign a_d    = (state_q == ST_LOAD_A && nx) ? I_sw : a_q;
  assign b_d    = (state_q == ST_LOAD_B && nx) ? I_sw : b_q;
  assign op_d   = (state_q == ST_LOAD_OP && nx) ? I_sw[NB_OP-1:0] : op_q;
  assign res_d  = (state_q == ST_EXEC) ? alu_res : clr ? '0 : res_q;
  assign ovf_d  = (state_q == ST_EXEC) ? alu_ovf : clr ? 1'b0 : ovf_q;
  assign zero_d = (state_q == ST_EXEC) ? alu_zero : clr ? 1'b0 : zero_q;
  assign led_d  = (state_d == ST_RESULT) ? res_d : I_sw;
  // Output registers are loaded from next-state values so they line up with the state change.
  always_ff @(posedge I_clk) begin
    if (reset_button) begin
      state_q     <= ST_LOAD_A;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      res_q       <= '0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      led_q       <= '0;
      ovf_out_q   <= 1'b0;
      zero_out_q  <= 1'b0;
      state_out_q <= 3'b001;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      res_q       <= res_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      led_q       <= led_d;
      ovf_out_q   <= (state_d == ST_RESULT) && ovf_d;
      zero_out_q  <= (state_d == ST_RESULT) && zero_d;
      state_out_q <= state_onehot(state_d);
      valid_q     <= state_d == ST_RESULT;
    end
  end
  assign O_led      = led_q;
  assign O_overflow = ovf_out_q;
  assign O_zero     = zero_out_q;
  assign O_state    = state_out_q;
  assign O_valid    = valid_q;
endmodule

// File: tb/tb_alu_step_loader.sv
// tb_alu_step_loader: randomized and directed checks of the step sequencer against an arithmetic model.
module tb_alu_step_loader;
  logic       clk = 1'b0;
  logic       rst;
  logic       bn;
  logic       bb;
  logic [7:0] sw;
  logic [7:0] led;
  logic       ovf;
  logic       zero;
  logic [2:0] st;
  logic       valid;
  int         n_vec = 0;
  int         n_bad = 0;
  always #5 clk = ~clk;
  alu_step_loader #(.NB_DATA(8), .NB_OP(6), .DEBOUNCE_CYCLES(4)) dut (
    .I_clk(clk), .reset_button(rst), .I_sw(sw), .I_btn_next(bn), .I_btn_back(bb),
    .O_led(led), .O_overflow(ovf), .O_zero(zero), .O_state(st), .O_valid(valid)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic press(input logic nx, input logic bk, input int hold);
    bn = nx;
    bb = bk;
    cyc(hold);
    bn = 1'b0;
    bb = 1'b0;
    cyc(14);
  endtask
  function automatic logic [2:0] onehot(input int s);
    return s == 0 ? 3'b001 : s == 1 ? 3'b010 : s == 2 ? 3'b100 : 3'b000;
  endfunction
  function automatic void ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op,
                                  output logic [7:0] r, output logic v);
    int sa, sb, t;
    sa = $signed(a);
    sb = $signed(b);
    t  = 0;
    v  = 1'b0;
    case (op)
      6'b100000: begin t = sa + sb; v = (t > 127) || (t < -128); end
      6'b100010: begin t = sa - sb; v = (t > 127) || (t < -128); end
      6'b100100: t = a & b;
      6'b100101: t = a | b;
      6'b100110: t = a ^ b;
      6'b100111: t = ~(a | b);
      6'b000011: t = sa >>> b;
      6'b000010: t = a >> b;
      default:   t = 0;
    endcase
    r = t[7:0];
  endfunction
  task automatic do_exec(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    logic [7:0] r;
    logic       v;
    int         k;
    ref_alu(a, b, op, r, v);
    sw = {2'($urandom_range(0, 3)), op};
    bn = 1'b1;
    for (k = 0; k < 40 && st != 3'b000; k++) cyc(1);
    chk("exec_reached", 32'(k < 40), 1);
    chk("exec_not_valid", valid, 0);
    cyc(1);
    chk("res_valid", valid, 1);
    chk("res_value", led, r);
    chk("res_ovf", ovf, v);
    chk("res_zero", zero, r == 8'd0);
    bn = 1'b0;
    cyc(14);
    chk("res_hold", led, r);
  endtask
  task automatic run(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    sw = a;
    press(1, 0, 12);
    chk("state_b", st, onehot(1));
    chk("echo_a", led, a);
    sw = b;
    press(1, 0, 12);
    chk("state_op", st, onehot(2));
    do_exec(a, b, op);
    sw = 8'($urandom);
    press(1, 0, 12);
    chk("back_a", st, onehot(0));
    chk("back_a_valid", valid, 0);
    chk("back_a_ovf", ovf, 0);
    chk("back_a_zero", zero, 0);
    chk("back_a_echo", led, sw);
  endtask
  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    ops = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b000011, 6'b000010};
    rst = 1'b1;
    bn  = 1'b0;
    bb  = 1'b0;
    sw  = 8'h00;
    cyc(2);
    chk("rst_state", st, 3'b001);
    chk("rst_led", led, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    chk("rst_valid", valid, 0);
    rst = 1'b0;
    cyc(10);
    run(8'h7F, 8'h01, 6'b100000);
    run(8'd5, 8'd5, 6'b100010);
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
      run(8'($urandom), 8'($urandom), op);
    end
    sw = 8'h10;
`ifdef ALU_STEP_DEBOUNCE_EN
    repeat (3) begin
      bn = 1'b1;
      cyc(3);
      bn = 1'b0;
      cyc(10);
    end
    chk("glitch_ignored", st, onehot(0));
`endif
    press(1, 0, 50);
    chk("held_one_step", st, onehot(1));
    sw = 8'h33;
    press(1, 0, 12);
    chk("b_first", st, onehot(2));
    press(0, 1, 12);
    chk("back_to_b", st, onehot(1));
    sw = 8'h02;
    press(1, 0, 12);
    chk("b_recaptured", st, onehot(2));
    do_exec(8'h10, 8'h02, 6'b100000);
    press(1, 1, 12);
    chk("both_ignored", st, 3'b000);
    chk("both_valid", valid, 1);
    press(0, 1, 12);
    chk("result_back", st, onehot(2));
    chk("result_back_valid", valid, 0);
    bn = 1'b1;
    cyc(5);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    sw  = 8'h5A;
    cyc(30);
    chk("rst_held_state", st, onehot(0));
    chk("rst_held_echo", led, 8'h5A);
    bn = 1'b0;
    cyc(14);
    chk("release_no_pulse", st, onehot(0));
    press(1, 0, 12);
    chk("repress_advance", st, onehot(1));
    sw = 8'h00;
    press(1, 0, 12);
    do_exec(8'h5A, 8'h00, 6'b100000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
